// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for mem_port_arbiter: fetch port, data port,
// pipeline stalls and the single-ported memory handshake.
interface mem_port_arbiter_if;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IValid;
    logic        IErr;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [3:0]  DBe;
    logic [31:0] DRData;
    logic        DValid;
    logic        DErr;
    logic        StallF;
    logic        StallM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic [31:0] MemRData;
    logic        MemAck;

    // master: the arbiter; slave: pipeline requesters plus memory
    modport master (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData, MemAck,
        output IRData, IValid, IErr, DRData, DValid, DErr, StallF, StallM,
               MemReq, MemWe, MemAddr, MemWData, MemBe
    );
    modport slave (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData, MemAck,
        input  IRData, IValid, IErr, DRData, DValid, DErr, StallF, StallM,
               MemReq, MemWe, MemAddr, MemWData, MemBe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory: one transaction in flight,
// data priority with a bounded fetch-starvation streak, and an ack watchdog.
module mem_port_arbiter #(
    parameter int MAXD    = 4,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    localparam logic [3:0] MAXD_C   = 4'(MAXD);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_valid_q, i_valid_d;
    logic        i_err_q, i_err_d;
    logic        d_valid_q, d_valid_d;
    logic        d_err_q, d_err_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        i_err_d     = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                // Data wins unless a waiting fetch has already seen MAXD data grants.
                if (bus.DReq && (!bus.IReq || streak_q < MAXD_C)) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.DWe;
                    mem_addr_d  = bus.DAddr;
                    mem_wdata_d = bus.DWe ? bus.DWData : 32'd0;
                    mem_be_d    = bus.DWe ? bus.DBe : 4'hF;
                    if (!bus.IReq)
                        streak_d = '0;
                    else if (streak_q != MAXD_C)
                        streak_d = streak_q + 4'd1;
                end else if (bus.IReq) begin
                    state_d     = I_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.IAddr;
                    mem_wdata_d = 32'd0;
                    mem_be_d    = 4'hF;
                    streak_d    = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.MemAck) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == I_BUSY) begin
                        i_rdata_d = bus.MemRData;
                        i_valid_d = 1'b1;
                    end else begin
                        if (!mem_we_q)
                            d_rdata_d = bus.MemRData;
                        d_valid_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abandoned access: report the error and return zero data.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == I_BUSY) begin
                        i_rdata_d = 32'd0;
                        i_err_d   = 1'b1;
                    end else begin
                        d_rdata_d = 32'd0;
                        d_err_d   = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            i_err_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            i_err_q     <= i_err_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.MemReq   = mem_req_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWData = mem_wdata_q;
    assign bus.MemBe    = mem_be_q;
    assign bus.IRData   = i_rdata_q;
    assign bus.DRData   = d_rdata_q;
    assign bus.IValid   = i_valid_q;
    assign bus.IErr     = i_err_q;
    assign bus.DValid   = d_valid_q;
    assign bus.DErr     = d_err_q;
    // An error pulse leaves the stall up; the pipeline takes the trap from there.
    assign bus.StallF   = bus.IReq & ~i_valid_q;
    assign bus.StallM   = bus.DReq & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues/responses are queued
// as stimulus is driven and checked as the DUT produces them.
module tb_mem_port_arbiter;
    localparam logic [3:0] K_IV = 4'b1000, K_IE = 4'b0100, K_DV = 4'b0010, K_DE = 4'b0001;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } iss_t;
    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    mem_port_arbiter_if bus ();

    logic        model_ack = 1'b0, man_ack = 1'b0;
    logic [31:0] model_rdata = '0, man_rdata = '0;
    bit          ack_en = 1'b1;
    int          ack_lat = 1;
    int          n_chk = 0, n_fail = 0;
    iss_t        iss_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] last_d;

    assign bus.MemAck   = model_ack | man_ack;
    assign bus.MemRData = man_ack ? man_rdata : model_rdata;

    mem_port_arbiter #(.MAXD(4), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_iss(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        iss_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.be = be;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [3:0] k, input logic [31:0] d);
        rsp_t e;
        e.kind = k; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Memory model: acks ack_lat cycles after MemReq is first seen high.
    initial begin
        bit req_seen = 1'b0;
        int wait_cnt = 0;
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (bus.MemReq && ack_en) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    wait_cnt = ack_lat;
                end
                if (wait_cnt == 0) begin
                    model_ack   = 1'b1;
                    model_rdata = mem_val(bus.MemAddr);
                end
                wait_cnt--;
            end
            if (!bus.MemReq) req_seen = 1'b0;
        end
    end

    // Monitor: issues on MemReq rise, responses on any Valid/Err pulse, stalls every cycle.
    initial begin
        logic prev_req = 1'b0;
        iss_t ei;
        rsp_t er;
        logic [3:0] kind;
        forever begin
            @(negedge clk);
            if (bus.MemReq && !prev_req) begin
                chk("iss_q_nonempty", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    ei = iss_q.pop_front();
                    chk("iss_addr", bus.MemAddr, ei.addr);
                    chk("iss_we_be", {27'd0, bus.MemWe, bus.MemBe}, {27'd0, ei.we, ei.be});
                    chk("iss_wdata", bus.MemWData, ei.wdata);
                end
            end
            prev_req = bus.MemReq;
            kind = {bus.IValid, bus.IErr, bus.DValid, bus.DErr};
            if (kind != 4'b0) begin
                chk("rsp_q_nonempty", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_q.size() > 0) begin
                    er = rsp_q.pop_front();
                    chk("rsp_kind", {28'd0, kind}, {28'd0, er.kind});
                    chk("rsp_data", (er.kind[3] | er.kind[2]) ? bus.IRData : bus.DRData, er.data);
                end
            end
            chk("stall_f", 32'(bus.StallF), 32'(bus.IReq & ~bus.IValid));
            chk("stall_m", 32'(bus.StallM), 32'(bus.DReq & ~bus.DValid));
        end
    end

    task automatic wait_done(input bit want_d, output int busy);
        bit seen = 1'b0;
        busy = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus.MemReq) busy++;
            seen = want_d ? (bus.DValid | bus.DErr) : (bus.IValid | bus.IErr);
        end
        chk(want_d ? "wait_d" : "wait_i", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b1;
        bus.IReq = 1'b1; bus.IAddr = 32'h40;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h300; bus.DWData = '0; bus.DBe = 4'h0;

        // Reset held two cycles with both requests up
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_memreq", 32'(bus.MemReq), 32'd0);
            chk("rst_valids", {28'd0, bus.IValid, bus.IErr, bus.DValid, bus.DErr}, 32'd0);
            chk("rst_memaddr", bus.MemAddr, 32'd0);
            chk("rst_irdata", bus.IRData, 32'd0);
            chk("rst_drdata", bus.DRData, 32'd0);
        end
        push_iss(32'h300, 1'b0, 32'd0, 4'hF);
        push_rsp(K_DV, mem_val(32'h300));
        reset = 1'b0;
        wait_done(1'b1, b);
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        last_d = mem_val(32'h300);
        @(posedge clk); #1;

        // Single fetch, ack 3 cycles after MemReq
        ack_lat = 3;
        bus.IReq = 1'b1; bus.IAddr = 32'h10;
        push_iss(32'h10, 1'b0, 32'd0, 4'hF);
        push_rsp(K_IV, 32'h0050_0093);
        wait_done(1'b0, b);
        bus.IReq = 1'b0;
        chk("fetch_busy", 32'(b), 32'd4);
        @(posedge clk); #1;

        // Simultaneous fetch and load: data first
        ack_lat = 1;
        bus.IReq = 1'b1; bus.IAddr = 32'h20;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h100;
        push_iss(32'h100, 1'b0, 32'd0, 4'hF);
        push_iss(32'h20, 1'b0, 32'd0, 4'hF);
        push_rsp(K_DV, mem_val(32'h100));
        push_rsp(K_IV, mem_val(32'h20));
        wait_done(1'b1, b);
        bus.DReq = 1'b0;
        chk("simul_stallf", 32'(bus.StallF), 32'd1);
        wait_done(1'b0, b);
        bus.IReq = 1'b0;
        @(posedge clk); #1;

        // Starvation: both held, grant order D,D,D,D,I,D,D,D,D,I
        bus.IReq = 1'b1; bus.IAddr = 32'h40;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h180;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push_iss(32'h40, 1'b0, 32'd0, 4'hF);
                push_rsp(K_IV, mem_val(32'h40));
            end else begin
                push_iss(32'h180, 1'b0, 32'd0, 4'hF);
                push_rsp(K_DV, mem_val(32'h180));
            end
        end
        for (int k = 0; k < 10; k++)
            wait_done(!(k == 4 || k == 9), b);
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        last_d = mem_val(32'h180);
        @(posedge clk); #1;

        // Store: DRData must keep the previous load value
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h200;
        bus.DWData = 32'hDEAD_BEEF; bus.DBe = 4'b0011;
        push_iss(32'h200, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        push_rsp(K_DV, last_d);
        wait_done(1'b1, b);
        bus.DReq = 1'b0; bus.DWe = 1'b0;
        @(posedge clk); #1;

        // Timeout: no ack, DErr with zeroed DRData after 8 busy cycles
        ack_en = 1'b0;
        bus.DReq = 1'b1; bus.DAddr = 32'h240;
        push_iss(32'h240, 1'b0, 32'd0, 4'hF);
        push_rsp(K_DE, 32'd0);
        wait_done(1'b1, b);
        bus.DReq = 1'b0;
        chk("tmo_busy", 32'(b), 32'd8);
        @(posedge clk); #1;

        // Reset in I_BUSY, then a late ack must not complete anything
        bus.IReq = 1'b1; bus.IAddr = 32'h60;
        push_iss(32'h60, 1'b0, 32'd0, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_busy_req", 32'(bus.MemReq), 32'd1);
        reset = 1'b1; bus.IReq = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_req", 32'(bus.MemReq), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        man_rdata = 32'hCAFE_F00D; man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_ack_silent", {30'd0, bus.IValid, bus.IErr}, 32'd0);
            chk("late_ack_noreq", 32'(bus.MemReq), 32'd0);
        end

        chk("iss_q_left", 32'(iss_q.size()), 32'd0);
        chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
